tiny_cpu_mem_arbiter: RTL



---
 rtl/tiny_cpu_pkg.sv | 37 +++
 rtl/tiny_cpu_prio_select.sv | 30 +++
 rtl/tiny_cpu_mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_pkg.sv
// =============================================================================
// Package     : tiny_cpu_pkg
// Description : Shared constants for the tiny CPU external memory arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package tiny_cpu_pkg;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DEBUG = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] XFER = 2'd3;

    localparam logic [7:0] OE_OUT = 8'hFF;
    localparam logic [7:0] OE_IN  = 8'h00;

    // Picks the 8-bit lane of a {debug, data, fetch} bundle named by a one-hot id.
    function automatic logic [7:0] lane_sel(input logic [23:0] lanes, input logic [2:0] onehot);
        logic [7:0] sel;
        sel = 8'h00;
        if (onehot[REQ_DEBUG])
            sel = lanes[23:16];
        else if (onehot[REQ_DATA])
            sel = lanes[15:8];
        else if (onehot[REQ_FETCH])
            sel = lanes[7:0];
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tiny_cpu_prio_select.sv
// =============================================================================
// Module      : tiny_cpu_prio_select
// Description : Fixed-priority pick (debug > data > fetch) with fetch override.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tiny_cpu_prio_select
    import tiny_cpu_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_starve_hit,
    output logic [2:0] o_winner
);

    always_comb begin
        o_winner = 3'b000;
        if (i_starve_hit && i_req[REQ_FETCH])
            o_winner[REQ_FETCH] = 1'b1;
        else if (i_req[REQ_DEBUG])
            o_winner[REQ_DEBUG] = 1'b1;
        else if (i_req[REQ_DATA])
            o_winner[REQ_DATA] = 1'b1;
        else if (i_req[REQ_FETCH])
            o_winner[REQ_FETCH] = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/tiny_cpu_mem_arbiter.sv
// =============================================================================
// Module      : tiny_cpu_mem_arbiter
// Description : Sequences fetch/data/debug transactions on the muxed uio bus.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tiny_cpu_mem_arbiter
    import tiny_cpu_pkg::*;
#(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  req_we,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [7:0]  rdata,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        bus_ale,
    output logic        bus_re,
    output logic        bus_we
);

    localparam logic [3:0] c_WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [1:0] c_AFTER_ADDR = (WAIT_CYCLES > 0) ? WAIT : XFER;

    logic [1:0] r_state_q, w_state_d;
    logic [3:0] r_wait_q, w_wait_d;
    logic [3:0] r_starve_q, w_starve_d;
    logic [2:0] r_id_q, w_id_d;
    logic       r_we_q, w_we_d;
    logic [7:0] r_addr_q, w_addr_d;
    logic [7:0] r_wdata_q, w_wdata_d;
    logic [2:0] r_gnt_q, w_gnt_d;
    logic [2:0] r_done_q, w_done_d;
    logic [7:0] r_rdata_q, w_rdata_d;

    logic [2:0] w_elig;
    logic [2:0] w_winner;
    logic       w_starve_hit;

    // The requester being retired this cycle still shows req high; keep it out.
    assign w_elig       = req & ~r_done_q;
    assign w_starve_hit = (r_starve_q == c_STARVE_MAX);

    tiny_cpu_prio_select u_prio (
        .i_req        (w_elig),
        .i_starve_hit (w_starve_hit),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_wait_d   = r_wait_q;
        w_starve_d = r_starve_q;
        w_id_d     = r_id_q;
        w_we_d     = r_we_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_gnt_d    = 3'b000;
        w_done_d   = 3'b000;
        w_rdata_d  = r_rdata_q;
        case (r_state_q)
            IDLE: begin
                if (|w_winner) begin
                    w_state_d = ADDR;
                    w_id_d    = w_winner;
                    w_gnt_d   = w_winner;
                    w_we_d    = |(req_we & w_winner);
                    w_addr_d  = lane_sel(req_addr, w_winner);
                    w_wdata_d = lane_sel(req_wdata, w_winner);
                    if (w_winner[REQ_FETCH])
                        w_starve_d = 4'd0;
                    else if (w_elig[REQ_FETCH] && !w_starve_hit)
                        w_starve_d = r_starve_q + 4'd1;
                end
            end
            ADDR: begin
                w_wait_d  = c_WAIT_LOAD;
                w_state_d = c_AFTER_ADDR;
            end
            WAIT: begin
                if (r_wait_q == 4'd0)
                    w_state_d = XFER;
                else
                    w_wait_d = r_wait_q - 4'd1;
            end
            XFER: begin
                w_state_d = IDLE;
                w_done_d  = r_id_q;
                if (!r_we_q)
                    w_rdata_d = bus_in;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_out = 8'h00;
        bus_oe  = OE_IN;
        bus_ale = 1'b0;
        bus_re  = 1'b0;
        bus_we  = 1'b0;
        case (r_state_q)
            ADDR: begin
                bus_out = r_addr_q;
                bus_oe  = OE_OUT;
                bus_ale = 1'b1;
            end
            WAIT: begin
                if (r_we_q) begin
                    bus_out = r_wdata_q;
                    bus_oe  = OE_OUT;
                end
            end
            XFER: begin
                if (r_we_q) begin
                    bus_out = r_wdata_q;
                    bus_oe  = OE_OUT;
                    bus_we  = 1'b1;
                end else begin
                    bus_re  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_wait_q   <= 4'd0;
            r_starve_q <= 4'd0;
            r_id_q     <= 3'b000;
            r_we_q     <= 1'b0;
            r_addr_q   <= 8'h00;
            r_wdata_q  <= 8'h00;
            r_gnt_q    <= 3'b000;
            r_done_q   <= 3'b000;
            r_rdata_q  <= 8'h00;
        end else begin
            r_state_q  <= w_state_d;
            r_wait_q   <= w_wait_d;
            r_starve_q <= w_starve_d;
            r_id_q     <= w_id_d;
            r_we_q     <= w_we_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_gnt_q    <= w_gnt_d;
            r_done_q   <= w_done_d;
            r_rdata_q  <= w_rdata_d;
        end
    end

    assign gnt   = r_gnt_q;
    assign done  = r_done_q;
    assign rdata = r_rdata_q;

endmodule

`default_nettype wire
